// File: rtl/fruit_drop_ctrl_if.sv
// rtl/fruit_drop_ctrl_if.sv - scan, command and draw/pulse bundle for one fruit controller
interface fruit_drop_ctrl_if;
   logic        startOfFrame;
   logic [10:0] pixelX;
   logic [10:0] pixelY;
   logic        dropCmd;
   logic        playerHit;
   logic        enemyHit;
   logic [7:0]  fruit_type;
   logic        drawRequest;
   logic [10:0] topLeftX;
   logic [10:0] topLeftY;
   logic        scorePulse;
   logic        enemyKillPulse;

   modport master (
      output startOfFrame, pixelX, pixelY, dropCmd, playerHit, enemyHit,
      input  fruit_type, drawRequest, topLeftX, topLeftY, scorePulse, enemyKillPulse
   );

   modport slave (
      input  startOfFrame, pixelX, pixelY, dropCmd, playerHit, enemyHit,
      output fruit_type, drawRequest, topLeftX, topLeftY, scorePulse, enemyKillPulse
   );
endinterface

// File: rtl/fruit_drop_ctrl.sv
// rtl/fruit_drop_ctrl.sv - per-fruit hang/fall/gone/respawn controller; optional X sway via FRUIT_SWAY_EN
module fruit_drop_ctrl #(
   parameter int          FRUIT_W        = 32,
   parameter int          FRUIT_H        = 32,
   parameter logic [10:0] INIT_X         = 11'd200,
   parameter logic [10:0] INIT_Y         = 11'd64,
   parameter int          FALL_SPEED     = 4,
   parameter logic [10:0] FLOOR_Y        = 11'd447,
   parameter logic [7:0]  FRUIT_CODE     = 8'd1,
   parameter int          RESPAWN_FRAMES = 120
) (
   input  logic              clk,
   input  logic              reset,
   fruit_drop_ctrl_if.slave  bus
);

   localparam int CNT_W = (RESPAWN_FRAMES > 2) ? $clog2(RESPAWN_FRAMES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((RESPAWN_FRAMES > 0) ? RESPAWN_FRAMES - 1 : 0);
   localparam logic [10:0] Y_CLAMP = FLOOR_Y - 11'(FRUIT_H - 1);

   typedef enum logic [1:0] {ST_HANG, ST_FALL, ST_GONE} state_t;

   state_t           state_q, state_d;
   logic [10:0]      y_q, y_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             enemy_prev_q;
   logic             draw_q, draw_d;
   logic [7:0]       type_q, type_d;
   logic             score_q, score_d;
   logic             kill_q, kill_d;
   logic [10:0]      x_cur;

   logic             floor_hit;
   logic             respawn_due;
   logic             enemy_rise;
   logic             in_box;
   logic [11:0]      x_end, y_end;

   // Shared decisions: floor reach on this frame's step, respawn on this frame, enemy rising edge
   always_comb begin
      floor_hit   = ({1'b0, y_q} + 12'(FALL_SPEED + FRUIT_H - 1)) >= {1'b0, FLOOR_Y};
      respawn_due = (RESPAWN_FRAMES != 0) && (cnt_q == CNT_LAST);
      enemy_rise  = bus.enemyHit & ~enemy_prev_q;
      x_end       = {1'b0, x_cur} + 12'(FRUIT_W - 1);
      y_end       = {1'b0, y_q} + 12'(FRUIT_H - 1);
      in_box      = (bus.pixelX >= x_cur) && ({1'b0, bus.pixelX} <= x_end) &&
                    (bus.pixelY >= y_q)   && ({1'b0, bus.pixelY} <= y_end);
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= ST_HANG;
      else       state_q <= state_d;
   end

   // Next-state logic; eating beats dropping in HANG, collisions are ignored outside their state
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_HANG: begin
            if (bus.playerHit)    state_d = ST_GONE;
            else if (bus.dropCmd) state_d = ST_FALL;
         end
         ST_FALL: begin
            if (bus.startOfFrame && floor_hit) state_d = ST_GONE;
         end
         ST_GONE: begin
            if (bus.startOfFrame && respawn_due) state_d = ST_HANG;
         end
         default: state_d = ST_HANG;
      endcase
   end

   // Registered outputs: draw box test against the current position, one-clock event pulses
   always_comb begin
      draw_d  = (state_q != ST_GONE) && in_box;
      type_d  = draw_d ? FRUIT_CODE : 8'd0;
      score_d = (state_q == ST_HANG) && bus.playerHit;
      kill_d  = (state_q == ST_FALL) && enemy_rise;
   end

   // Y position and respawn frame counter
   always_comb begin
      y_d   = y_q;
      cnt_d = cnt_q;
      if (bus.startOfFrame) begin
         if (state_q == ST_FALL) begin
            y_d = floor_hit ? Y_CLAMP : y_q + 11'(FALL_SPEED);
         end else if (state_q == ST_GONE) begin
            if (respawn_due) begin
               cnt_d = '0;
               y_d   = INIT_Y;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
      end
   end

   // Datapath and output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         y_q          <= INIT_Y;
         cnt_q        <= '0;
         enemy_prev_q <= 1'b0;
         draw_q       <= 1'b0;
         type_q       <= 8'd0;
         score_q      <= 1'b0;
         kill_q       <= 1'b0;
      end else begin
         y_q          <= y_d;
         cnt_q        <= cnt_d;
         enemy_prev_q <= bus.enemyHit;
         draw_q       <= draw_d;
         type_q       <= type_d;
         score_q      <= score_d;
         kill_q       <= kill_d;
      end
   end

`ifdef FRUIT_SWAY_EN
   logic [10:0] x_q, x_d;
   logic [3:0]  sway_div_q, sway_div_d;
   logic [1:0]  sway_phase_q, sway_phase_d;

   // Sway only while hanging: every 16th frame steps the phase (centre, right, centre, left)
   always_comb begin
      x_d          = x_q;
      sway_div_d   = sway_div_q;
      sway_phase_d = sway_phase_q;
      if (bus.startOfFrame) begin
         if (state_q == ST_HANG) begin
            sway_div_d = sway_div_q + 4'd1;
            if (sway_div_q == 4'd15) sway_phase_d = sway_phase_q + 2'd1;
            case (sway_phase_d)
               2'd1:    x_d = INIT_X + 11'd2;
               2'd3:    x_d = INIT_X - 11'd2;
               default: x_d = INIT_X;
            endcase
         end else if (state_q == ST_GONE && respawn_due) begin
            sway_div_d   = '0;
            sway_phase_d = '0;
            x_d          = INIT_X;
         end
      end
   end

   // Sway registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         x_q          <= INIT_X;
         sway_div_q   <= '0;
         sway_phase_q <= '0;
      end else begin
         x_q          <= x_d;
         sway_div_q   <= sway_div_d;
         sway_phase_q <= sway_phase_d;
      end
   end

   assign x_cur = x_q;
`else
   assign x_cur = INIT_X;
`endif

   assign bus.drawRequest    = draw_q;
   assign bus.fruit_type     = type_q;
   assign bus.scorePulse     = score_q;
   assign bus.enemyKillPulse = kill_q;
   assign bus.topLeftX       = x_cur;
   assign bus.topLeftY       = y_q;

endmodule

// File: tb/tb_fruit_drop_ctrl.sv
// tb/tb_fruit_drop_ctrl.sv - directed plus randomized check of fruit_drop_ctrl against a frame-level model
module tb_fruit_drop_ctrl;
   localparam int FW = 32;
   localparam int FH = 32;
   localparam int IX = 200;
   localparam int IY = 64;
   localparam int SPD = 4;
   localparam int FLOOR = 447;
   localparam int CODE = 1;
   localparam int RF = 120;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   fruit_drop_ctrl_if bus();
   fruit_drop_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

   int n_checks = 0;
   int n_errors = 0;

   // model: 0 hanging, 1 falling, 2 gone
   int m_st, m_x, m_y, m_gone, m_hang_sof;
   bit m_prev_en;
   int kill_seen, score_seen;
`ifdef FRUIT_SWAY_EN
   int sway_off[4] = '{0, 2, 0, -2};
`endif

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_st = 0; m_x = IX; m_y = IY; m_gone = 0; m_hang_sof = 0; m_prev_en = 0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      bus.startOfFrame = 0; bus.dropCmd = 0; bus.playerHit = 0; bus.enemyHit = 0;
      #2;
      model_reset();
      check_val("rst_draw",  bus.drawRequest, 0);
      check_val("rst_type",  bus.fruit_type, 0);
      check_val("rst_score", bus.scorePulse, 0);
      check_val("rst_kill",  bus.enemyKillPulse, 0);
      check_val("rst_x",     bus.topLeftX, IX);
      check_val("rst_y",     bus.topLeftY, IY);
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic step();
      int px, py;
      bit e_draw, e_score, e_kill, sof, ph, dc, eh;
      px = bus.pixelX; py = bus.pixelY;
      sof = bus.startOfFrame; ph = bus.playerHit; dc = bus.dropCmd; eh = bus.enemyHit;
      e_draw  = (m_st != 2) && px >= m_x && px <= m_x + FW - 1 && py >= m_y && py <= m_y + FH - 1;
      e_score = (m_st == 0) && ph;
      e_kill  = (m_st == 1) && eh && !m_prev_en;
      case (m_st)
         0: begin
            if (sof) begin
               m_hang_sof++;
`ifdef FRUIT_SWAY_EN
               m_x = IX + sway_off[(m_hang_sof / 16) % 4];
`endif
            end
            if (ph) begin m_st = 2; m_gone = 0; end
            else if (dc) m_st = 1;
         end
         1: if (sof) begin
            if (m_y + SPD + FH - 1 >= FLOOR) begin m_y = FLOOR - FH + 1; m_st = 2; m_gone = 0; end
            else m_y += SPD;
         end
         default: if (sof) begin
            m_gone++;
            if (RF != 0 && m_gone == RF) begin
               m_st = 0; m_x = IX; m_y = IY; m_hang_sof = 0; m_gone = 0;
            end
         end
      endcase
      m_prev_en = eh;
      @(posedge clk); #1;
      check_val("draw",  bus.drawRequest, e_draw);
      check_val("type",  bus.fruit_type, e_draw ? CODE : 0);
      check_val("score", bus.scorePulse, e_score);
      check_val("kill",  bus.enemyKillPulse, e_kill);
      check_val("x",     bus.topLeftX, m_x);
      check_val("y",     bus.topLeftY, m_y);
      kill_seen  += int'(bus.enemyKillPulse);
      score_seen += int'(bus.scorePulse);
   endtask

   task automatic frame();
      bus.startOfFrame = 1; step();
      bus.startOfFrame = 0; step(); step();
   endtask

   initial begin
      int nf;
      bus.pixelX = 0; bus.pixelY = 0;
      do_reset();

      // scan at the top-left corner and just past the right edge
      bus.pixelX = 11'(IX); bus.pixelY = 11'(IY); step();
      check_val("t1_draw_on", bus.drawRequest, 1);
      check_val("t1_type_on", bus.fruit_type, 1);
      bus.pixelX = 11'(IX + 32); step();
      check_val("t1_draw_off", bus.drawRequest, 0);
      check_val("t1_type_off", bus.fruit_type, 0);
      bus.pixelX = 11'(IX + 31); bus.pixelY = 11'(IY + 31); step();
      check_val("t1_draw_corner", bus.drawRequest, 1);

      // eat and drop in the same clock
      bus.pixelX = 11'(IX); bus.pixelY = 11'(IY);
      bus.playerHit = 1; bus.dropCmd = 1; step();
      check_val("t2_score", bus.scorePulse, 1);
      bus.playerHit = 0; bus.dropCmd = 0; step();
      check_val("t2_score_clr", bus.scorePulse, 0);
      check_val("t2_draw_gone", bus.drawRequest, 0);
      check_val("t2_y_kept", bus.topLeftY, IY);
      do_reset();

      // drop then ten frames
      score_seen = 0;
      bus.dropCmd = 1; step(); bus.dropCmd = 0;
      repeat (10) frame();
      check_val("t3_y", bus.topLeftY, 104);
      check_val("t3_no_score", score_seen, 0);

      // reset mid-fall
      do_reset();
`ifdef FRUIT_SWAY_EN
      repeat (16) frame();
      check_val("t6_sway_x", bus.topLeftX, 202);
`endif

      // enemy held for five clocks while falling
      bus.dropCmd = 1; step(); bus.dropCmd = 0;
      frame();
      kill_seen = 0;
      bus.enemyHit = 1; repeat (5) step();
      bus.enemyHit = 0; step();
      check_val("t5_one_kill", kill_seen, 1);
      frame();
      check_val("t5_still_fall", bus.topLeftY, IY + 2 * SPD);

      // fall to the floor, then wait out the respawn
      nf = 0;
      for (int i = 0; i < 200 && m_st == 1; i++) begin frame(); nf++; end
      check_val("t4_frames", nf, 86);
      check_val("t4_clamp_y", bus.topLeftY, 416);
      bus.pixelX = 11'(m_x); bus.pixelY = 11'd416; step();
      check_val("t4_gone_nodraw", bus.drawRequest, 0);
      repeat (119) frame();
      check_val("t4_still_gone", bus.topLeftY, 416);
      frame();
      check_val("t4_respawn_y", bus.topLeftY, IY);
      check_val("t4_respawn_x", bus.topLeftX, IX);
      bus.pixelX = 11'(IX); bus.pixelY = 11'(IY); step();
      check_val("t4_respawn_draw", bus.drawRequest, 1);

      // randomized traffic
      for (int i = 0; i < 6000; i++) begin
         if ($urandom_range(0, 799) == 0) do_reset();
         bus.startOfFrame = ($urandom_range(0, 3) == 0);
         bus.dropCmd      = ($urandom_range(0, 29) == 0);
         bus.playerHit    = ($urandom_range(0, 59) == 0);
         if ($urandom_range(0, 3) == 0) bus.enemyHit = ~bus.enemyHit;
         bus.pixelX = 11'(m_x + int'($urandom_range(0, 40)) - 4);
         bus.pixelY = 11'(m_y + int'($urandom_range(0, 40)) - 4);
         step();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
